cpu_cmd_sequencer: RTL and testbench
====================================

Name: cpu_cmd_sequencer

Overview:
Hardware initiator for the cpu datapath (32x32 register file plus add/sub ALU). It accepts abstract commands (STORE, ADD, SUB, READ) over a valid/ready handshake and drives the cpu control fields (addressA, addressB, dataIn, opsel, outsel, asel, bsel, oen) for the required number of cycles. For READ, ADD and SUB it captures the cpu result (outPut, over) and returns it on a result valid/ready handshake. It replaces hand-timed stimulus and sits between a host or test controller and the cpu instance.

Parameters:
ALU_WAIT, 2, drive cycles held for ADD/SUB before outPut is sampled (legal range 1..15)
RD_WAIT, 1, drive cycles held for READ before outPut is sampled (legal range 1..15)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command
cmd_op  input  2  00 STORE, 01 ADD, 10 SUB, 11 READ
cmd_a  input  5  address A (ADD/SUB/READ)
cmd_b  input  5  address B (STORE destination, ADD/SUB operand)
cmd_data  input  32  STORE data
res_valid  output  1  result held
res_ready  input  1  result consumer ready
res_data  output  32  captured outPut
res_over  output  1  captured over
busy  output  1  high in any state except IDLE
cpu_addr_a  output  5  to cpu addressA
cpu_addr_b  output  5  to cpu addressB
cpu_data_in  output  32  to cpu dataIn
cpu_opsel  output  2  to cpu opsel
cpu_outsel  output  2  to cpu outsel
cpu_asel  output  1  to cpu asel
cpu_bsel  output  1  to cpu bsel
cpu_oen  output  1  to cpu oen
cpu_out  input  32  from cpu outPut
cpu_over  input  1  from cpu over

Behaviour:
- All outputs are registered. Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: cmd_ready=1, res_valid=0, res_data=0, res_over=0, busy=0. CPU fields take the IDLE encoding.
- IDLE encoding: addr_a=0, addr_b=0, data_in=0, opsel=01, outsel=00, asel=1, bsel=0, oen=0. This is non-writing.
- Command encodings (all with oen=1):
  - STORE: opsel=01, outsel=00, asel=0, bsel=0, addr_a=0, addr_b=cmd_b, data_in=cmd_data.
  - ADD: opsel=00, outsel=01, asel=1, bsel=1.
  - SUB: opsel=01, outsel=01, asel=1, bsel=1.
  - READ: opsel=01, outsel=00, asel=1, bsel=0, addr_b=cmd_a.
  - data_in=0 for ADD, SUB and READ.
- FSM states: IDLE, DRIVE, CAPTURE, RESP.
  - IDLE: when cmd_valid && cmd_ready at edge N, latch the command. In cycle N+1 the fields are driven, state is DRIVE, and cmd_ready=0.
  - DRIVE, STORE: held exactly 1 cycle; the cpu writes on the closing edge. Then return to IDLE with the IDLE encoding, so cmd_ready=1 in cycle N+2. No result is produced.
  - DRIVE, READ/ADD/SUB: hold the fields for RD_WAIT or ALU_WAIT cycles, counted by a 4-bit down-counter. Go to CAPTURE.
  - CAPTURE: fields still held. Sample cpu_out and cpu_over into res_data and res_over at the closing edge. Set res_valid=1 and restore the IDLE encoding. Go to RESP.
  - RESP: hold res_* stable while res_valid=1 && res_ready=0. On res_valid && res_ready, clear res_valid and go to IDLE; cmd_ready=1 in the next cycle.
- Read latency, acceptance edge to res_valid high: RD_WAIT+2 cycles. ADD/SUB latency: ALU_WAIT+2 cycles.
- Only one command is in flight. cmd_ready is 0 in DRIVE, CAPTURE and RESP, and cmd_valid is ignored there.
- cmd_valid may drop without effect while cmd_ready=0.
- cmd_op values are fully decoded; there are no illegal codes.
- Address and data values pass through unmodified with no arithmetic in this block. res_over is the cpu flag unaltered.
- Reset mid-operation: the state returns to IDLE at the reset edge and a pending result is discarded. A cpu write already driven during the reset edge still completes, because the cpu samples the same edge. No partial result is ever presented.
- If res_ready is already high when res_valid rises, the handshake completes in 1 cycle.

Optional Feature:
SEQ_OVF_STICKY_EN:
- Defined: adds ports ovf_sticky (output 1) and ovf_clr (input 1). ovf_sticky sets on any CAPTURE with cpu_over=1. It clears on ovf_clr=1 or rst. If set and clear occur in the same cycle, set wins. Reset value is 0.
- Undefined: these ports and the register do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset then four STOREs: 0xFFFFFFF1 at 0, 0x0000000F at 1, 0x23 at 2, 0x37 at 20 -> each has cpu_oen=1, asel=0, bsel=0 for exactly 1 cycle; res_valid stays 0; cmd_ready is back to 1 two cycles after each accept.
- ADD a=0, b=1 -> res_valid rises ALU_WAIT+2 cycles after accept with res_data=0x00000000 (cpu result), and the fields match the ADD encoding during DRIVE.
- SUB a=0, b=20 -> res_data=0xFFFFFFBA, res_over=0. READ a=2 -> res_data=0x23, with latency RD_WAIT+2.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data is stable, cmd_ready=0, and a cmd_valid pulse is ignored; on res_ready=1 the handshake completes and cmd_ready=1 on the next cycle.
- rst asserted during DRIVE of ADD -> next cycle has busy=0, cmd_ready=1, res_valid=0 and the IDLE encoding; a following READ a=1 works normally.
- With SEQ_OVF_STICKY_EN: STORE 0x7FFFFFFF at 3 and 0x1 at 4, then ADD 3,4 -> res_over=1 and ovf_sticky=1, which stays set after a later non-overflowing ADD and clears after an ovf_clr pulse.

Source files
------------

// File: rtl/cpu_cmd_sequencer_if.sv
// Command and result handshake bundle between a host/test controller and cpu_cmd_sequencer.
// master = host side, slave = sequencer side.
interface cpu_cmd_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_a;
    logic [4:0]  cmd_b;
    logic [31:0] cmd_data;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_over;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_data, res_ready,
        input  cmd_ready, res_valid, res_data, res_over
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_data, res_ready,
        output cmd_ready, res_valid, res_data, res_over
    );
endinterface

// File: rtl/cpu_cmd_sequencer.sv
// Turns STORE/ADD/SUB/READ commands into timed cpu control fields and returns captured results.
// Optional overflow sticky flag (ovf_sticky/ovf_clr) is enabled by defining SEQ_OVF_STICKY_EN.
module cpu_cmd_sequencer #(
    parameter int unsigned ALU_WAIT = 2,
    parameter int unsigned RD_WAIT  = 1
) (
    input  logic               clk,
    input  logic               rst,
    cpu_cmd_sequencer_if.slave bus,
    output logic               busy,
    output logic [4:0]         cpu_addr_a,
    output logic [4:0]         cpu_addr_b,
    output logic [31:0]        cpu_data_in,
    output logic [1:0]         cpu_opsel,
    output logic [1:0]         cpu_outsel,
    output logic               cpu_asel,
    output logic               cpu_bsel,
    output logic               cpu_oen,
    input  logic [31:0]        cpu_out,
    input  logic               cpu_over
`ifdef SEQ_OVF_STICKY_EN
    ,
    output logic               ovf_sticky,
    input  logic               ovf_clr
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] DRIVE   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] RESP    = 2'd3;

    localparam logic [1:0] OP_STORE = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    typedef struct packed {
        logic [4:0]  addr_a;
        logic [4:0]  addr_b;
        logic [31:0] data_in;
        logic [1:0]  opsel;
        logic [1:0]  outsel;
        logic        asel;
        logic        bsel;
        logic        oen;
    } fields_t;

    // Non-writing encoding presented whenever no command is being driven.
    localparam fields_t IDLE_FIELDS = '{5'd0, 5'd0, 32'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0};

    logic [1:0] state;
    logic [3:0] cnt;
    logic       is_store;
    fields_t    fld;

    assign cpu_addr_a  = fld.addr_a;
    assign cpu_addr_b  = fld.addr_b;
    assign cpu_data_in = fld.data_in;
    assign cpu_opsel   = fld.opsel;
    assign cpu_outsel  = fld.outsel;
    assign cpu_asel    = fld.asel;
    assign cpu_bsel    = fld.bsel;
    assign cpu_oen     = fld.oen;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            is_store      <= 1'b0;
            fld           <= IDLE_FIELDS;
            busy          <= 1'b0;
            bus.cmd_ready <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_over  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        state         <= DRIVE;
                        busy          <= 1'b1;
                        bus.cmd_ready <= 1'b0;
                        is_store      <= (bus.cmd_op == OP_STORE);
                        cnt           <= 4'd1;
                        case (bus.cmd_op)
                            OP_STORE: fld <= '{5'd0, bus.cmd_b, bus.cmd_data, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1};
                            OP_ADD: begin
                                fld <= '{bus.cmd_a, bus.cmd_b, 32'd0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1};
                                cnt <= 4'(ALU_WAIT);
                            end
                            OP_SUB: begin
                                fld <= '{bus.cmd_a, bus.cmd_b, 32'd0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b1};
                                cnt <= 4'(ALU_WAIT);
                            end
                            OP_READ: begin
                                fld <= '{bus.cmd_a, bus.cmd_a, 32'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1};
                                cnt <= 4'(RD_WAIT);
                            end
                        endcase
                    end
                end
                DRIVE: begin
                    if (cnt <= 4'd1) begin
                        if (is_store) begin
                            state         <= IDLE;
                            fld           <= IDLE_FIELDS;
                            busy          <= 1'b0;
                            bus.cmd_ready <= 1'b1;
                        end else begin
                            state <= CAPTURE;
                        end
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                CAPTURE: begin
                    state         <= RESP;
                    fld           <= IDLE_FIELDS;
                    bus.res_data  <= cpu_out;
                    bus.res_over  <= cpu_over;
                    bus.res_valid <= 1'b1;
                end
                RESP: begin
                    if (bus.res_ready) begin
                        state         <= IDLE;
                        busy          <= 1'b0;
                        bus.res_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef SEQ_OVF_STICKY_EN
    // Set has priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_sticky <= 1'b0;
        else if (state == CAPTURE && cpu_over)
            ovf_sticky <= 1'b1;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_cpu_cmd_sequencer.sv
// Scoreboard bench for cpu_cmd_sequencer with a behavioural cpu stub and a register-level reference model.
// Covers the SEQ_OVF_STICKY_EN build when that macro is defined.
module tb_cpu_cmd_sequencer;
    localparam int unsigned ALU_WAIT = 2;
    localparam int unsigned RD_WAIT  = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_cmd_sequencer_if bus ();

    logic        busy;
    logic [4:0]  cpu_addr_a, cpu_addr_b;
    logic [31:0] cpu_data_in, cpu_out;
    logic [1:0]  cpu_opsel, cpu_outsel;
    logic        cpu_asel, cpu_bsel, cpu_oen, cpu_over;
`ifdef SEQ_OVF_STICKY_EN
    logic        ovf_sticky;
    logic        ovf_clr;
`endif

    cpu_cmd_sequencer #(.ALU_WAIT(ALU_WAIT), .RD_WAIT(RD_WAIT)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy),
        .cpu_addr_a(cpu_addr_a), .cpu_addr_b(cpu_addr_b), .cpu_data_in(cpu_data_in),
        .cpu_opsel(cpu_opsel), .cpu_outsel(cpu_outsel), .cpu_asel(cpu_asel),
        .cpu_bsel(cpu_bsel), .cpu_oen(cpu_oen), .cpu_out(cpu_out), .cpu_over(cpu_over)
`ifdef SEQ_OVF_STICKY_EN
        , .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
`endif
    );

    // Behavioural cpu: register file written by the STORE path, combinational add/sub.
    logic [31:0] cpu_rf [32];
    logic [31:0] sa, sb;
    always @(posedge clk)
        if (cpu_oen && !cpu_asel && cpu_outsel == 2'b00) cpu_rf[cpu_addr_b] <= cpu_data_in;
    always_comb begin
        sa = cpu_asel ? cpu_rf[cpu_addr_a] : 32'h0;
        sb = cpu_bsel ? cpu_rf[cpu_addr_b] : cpu_data_in;
        cpu_out  = 32'hCCCC_CCCC;
        cpu_over = 1'b0;
        if (cpu_oen) begin
            if (cpu_outsel == 2'b00) cpu_out = cpu_bsel ? 32'hDEAD_BEEF : cpu_rf[cpu_addr_b];
            else if (cpu_outsel == 2'b01) begin
                if (cpu_opsel == 2'b00) begin
                    cpu_out  = sa + sb;
                    cpu_over = (sa[31] == sb[31]) && (cpu_out[31] != sa[31]);
                end else if (cpu_opsel == 2'b01) begin
                    cpu_out  = sa - sb;
                    cpu_over = (sa[31] != sb[31]) && (cpu_out[31] != sa[31]);
                end
            end
        end
    end

    typedef struct {
        logic [31:0] d;
        logic        o;
        int unsigned acc;
        int unsigned lat;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] ref_rf [32];
    int unsigned vectors = 0, miscompares = 0;
    int unsigned cyc = 0;
    int unsigned rr_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rr_mode)
            0:       bus.res_ready = 1'b1;
            1:       bus.res_ready = 1'($urandom_range(0, 1));
            default: bus.res_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [48:0] exp_fields(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                                               input logic [31:0] d);
        case (op)
            2'b00:   return {5'd0, b, d, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1};
            2'b01:   return {a, b, 32'd0, 2'b00, 2'b01, 1'b1, 1'b1, 1'b1};
            2'b10:   return {a, b, 32'd0, 2'b01, 2'b01, 1'b1, 1'b1, 1'b1};
            default: return {5'd0, a, 32'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b1};
        endcase
    endfunction

    function automatic logic [48:0] act_fields(input logic mask_a);
        return {mask_a ? 5'd0 : cpu_addr_a, cpu_addr_b, cpu_data_in, cpu_opsel, cpu_outsel,
                cpu_asel, cpu_bsel, cpu_oen};
    endfunction

    localparam logic [48:0] IDLE_ENC = {5'd0, 5'd0, 32'd0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0};

    // Called at a negedge; returns at the negedge after the accepting edge (STORE: one later).
    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b, input logic [31:0] d);
        int unsigned n = 0;
        exp_t e;
        longint s;
        while (!bus.cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            check("cmd_ready_timeout", bus.cmd_ready, 1'b1);
            return;
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_data  = d;
        e.acc = cyc + 1;
        case (op)
            2'b00: ref_rf[b] = d;
            2'b01, 2'b10: begin
                s = (op == 2'b01) ? longint'($signed(ref_rf[a])) + longint'($signed(ref_rf[b]))
                                  : longint'($signed(ref_rf[a])) - longint'($signed(ref_rf[b]));
                e.d = s[31:0];
                e.o = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                e.lat = ALU_WAIT + 2;
                sbq.push_back(e);
            end
            default: begin
                e.d = ref_rf[a];
                e.o = 1'b0;
                e.lat = RD_WAIT + 2;
                sbq.push_back(e);
            end
        endcase
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_a     = 5'($urandom);
        bus.cmd_b     = 5'($urandom);
        bus.cmd_data  = $urandom;
        check("drive_fields", act_fields(op == 2'b11), exp_fields(op, a, b, d));
        check("drive_cmd_ready", bus.cmd_ready, 1'b0);
        check("drive_busy", busy, 1'b1);
        if (op == 2'b00) begin
            @(negedge clk);
            check("store_ready_back", bus.cmd_ready, 1'b1);
            check("store_idle_fields", act_fields(1'b0), IDLE_ENC);
        end
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((busy || bus.res_valid || sbq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("drain", {busy, bus.res_valid, 32'(sbq.size())}, 34'd0);
    endtask

    // Monitor: pops the scoreboard on each rising res_valid and checks stability while held.
    logic        prev_v = 1'b0, hs_pending = 1'b0;
    logic [32:0] held;
    exp_t        me;
    always @(negedge clk) begin
        if (rst) begin
            prev_v     = 1'b0;
            hs_pending = 1'b0;
        end else begin
            if (hs_pending) begin
                check("post_hs_cmd_ready", bus.cmd_ready, 1'b1);
                check("post_hs_res_valid", bus.res_valid, 1'b0);
                hs_pending = 1'b0;
            end
            if (bus.res_valid && !prev_v) begin
                if (sbq.size() == 0) check("spurious_result", bus.res_valid, 1'b0);
                else begin
                    me = sbq.pop_front();
                    check("res_data", bus.res_data, me.d);
                    check("res_over", bus.res_over, me.o);
                    check("latency", cyc + 1 - me.acc, me.lat);
                    check("resp_idle_fields", act_fields(1'b0), IDLE_ENC);
                end
                held = {bus.res_over, bus.res_data};
            end else if (bus.res_valid) begin
                check("res_stable", {bus.res_over, bus.res_data}, held);
                check("resp_cmd_ready", bus.cmd_ready, 1'b0);
            end
            if (bus.res_valid && bus.res_ready) hs_pending = 1'b1;
            prev_v = bus.res_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int unsigned i = 0; i < 32; i++) begin
            cpu_rf[i] = 32'h0;
            ref_rf[i] = 32'h0;
        end
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 2'b00;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_data = '0;
`ifdef SEQ_OVF_STICKY_EN
        ovf_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1'b1);
        check("rst_res", {bus.res_valid, bus.res_over, bus.res_data}, 34'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_fields", act_fields(1'b0), IDLE_ENC);
        rst = 1'b0;
        @(negedge clk);

        issue(2'b00, 5'd0, 5'd0,  32'hFFFF_FFF1);
        issue(2'b00, 5'd0, 5'd1,  32'h0000_000F);
        issue(2'b00, 5'd0, 5'd2,  32'h0000_0023);
        issue(2'b00, 5'd0, 5'd20, 32'h0000_0037);
        issue(2'b01, 5'd0, 5'd1,  32'h0);
        wait_idle();
        issue(2'b10, 5'd0, 5'd20, 32'h0);
        wait_idle();
        issue(2'b11, 5'd2, 5'd0,  32'h0);
        wait_idle();

        // Backpressure with an ignored command pulse.
        rr_mode = 2;
        issue(2'b11, 5'd20, 5'd0, 32'h0);
        for (int unsigned n = 0; n < 20 && !bus.res_valid; n++) @(negedge clk);
        for (int unsigned k = 0; k < 5; k++) begin
            check("bp_cmd_ready", bus.cmd_ready, 1'b0);
            bus.cmd_valid = (k == 1);
            bus.cmd_op    = 2'b00;
            bus.cmd_b     = 5'd2;
            bus.cmd_data  = 32'h5555_5555;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        rr_mode = 0;
        wait_idle();
        issue(2'b11, 5'd2, 5'd0, 32'h0);
        wait_idle();

        // Reset during DRIVE of an ADD.
        issue(2'b01, 5'd0, 5'd20, 32'h0);
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        check("midrst_status", {busy, bus.cmd_ready, bus.res_valid}, 3'b010);
        check("midrst_fields", act_fields(1'b0), IDLE_ENC);
        rst = 1'b0;
        issue(2'b11, 5'd1, 5'd0, 32'h0);
        wait_idle();

`ifdef SEQ_OVF_STICKY_EN
        check("sticky_clear_init", ovf_sticky, 1'b0);
        issue(2'b00, 5'd0, 5'd3, 32'h7FFF_FFFF);
        issue(2'b00, 5'd0, 5'd4, 32'h0000_0001);
        issue(2'b01, 5'd3, 5'd4, 32'h0);
        wait_idle();
        check("sticky_set", ovf_sticky, 1'b1);
        issue(2'b01, 5'd0, 5'd1, 32'h0);
        wait_idle();
        check("sticky_hold", ovf_sticky, 1'b1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        check("sticky_cleared", ovf_sticky, 1'b0);
`endif

        // Randomized traffic over a small address window so reads hit stored data.
        rr_mode = 1;
        for (int unsigned i = 0; i < 40; i++)
            issue(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom);
        rr_mode = 0;
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
